dbus_arbiter: RTL and testbench
===============================

# dbus_arbiter

Shares one peripheral `data_bus` slave, such as the GPIO block, between `NUM_MASTERS` requesting masters, for example the core LSU and a debug/DMA port. It grants one master at a time and forwards that master's request fields to the slave. It allows exactly one outstanding transaction and routes the slave's `rvalid`/`rdata` back to the master that issued it. It sits between the masters' `data_bus.master` ports and the slave's `data_bus.slave` port.

## Interface
- `NUM_MASTERS`, default 2: number of requesting masters, legal range 2..8.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `m[NUM_MASTERS]` `data_bus.slave` array: master-side ports with fields `req`, `we`, `addr`, `wdata`, `gnt`, `rvalid`, `rdata`.
- `s` `data_bus.master`: slave-side port to the peripheral.
- `busy` output 1: a transaction is outstanding; a diagnostic and status bit.

## Operation
- FSM states: IDLE and WAIT_RSP.
- **Arbitration**
  - Runs combinationally in IDLE, and in WAIT_RSP during the cycle when `s.rvalid`=1.
  - Winner `sel` is the first master with `m[i].req`=1, searched from index `rr_ptr` upward with modulo `NUM_MASTERS` wrap.
- **Forwarding**
  - `s.req`=1 only when arbitration is active and at least one master requests.
  - `s.we`, `s.addr`, `s.wdata` come from `m[sel]`.
  - When `s.req`=0 these fields are driven to 0.
- **Grant**
  - `m[sel].gnt` = `s.gnt` when `s.req`=1. All other `m[i].gnt`=0.
  - A master that is not granted holds `req` and its fields stable until it is granted.
- **Transitions**
  - On `s.req && s.gnt`: register `owner<=sel`, go to WAIT_RSP, and set `rr_ptr<=(sel+1) mod NUM_MASTERS`.
  - In WAIT_RSP with `s.rvalid`=1: if a new grant happens in the same cycle, stay in WAIT_RSP with the new owner. Otherwise go to IDLE.
  - In WAIT_RSP with `s.rvalid`=0: no arbitration, `s.req`=0, and all `gnt`=0.
- **Response routing**
  - `m[owner].rvalid` = `s.rvalid` while in WAIT_RSP.
  - `m[owner].rdata` = `s.rdata`.
  - Non-owners see `rvalid`=0 and `rdata`=0.
  - `rvalid` is returned for writes too, because the slave asserts it for every grant.
- **Status:** `busy`=1 exactly when the state is WAIT_RSP.
- **Out-of-protocol input:** an `s.rvalid` in IDLE is ignored and routed to no master. Under `DBUS_ARB_CHECK_EN` it fires an assertion.

## Timing
- **Reset values:** state IDLE, `owner`=0, `rr_ptr`=0, `busy`=0, all `m[i].gnt`/`rvalid`=0, all `s` request fields 0.
- **Reset mid-transaction:** the FSM returns to IDLE immediately, and any in-flight response is dropped.
- **Request path:** combinational from `m[i].req` through `s.req` and `s.gnt` to `m[i].gnt`. It adds zero cycles on top of the slave's combinational `gnt`.
- **Latency:** the response reaches the master in the same cycle the slave asserts `rvalid`. With a slave whose `rvalid` follows its grant by one cycle, that is 1 cycle after grant.
- **Throughput:** one transaction per cycle sustained. The grant for transaction N+1 coincides with the `rvalid` of transaction N.
- **Simultaneous requests:** all masters requesting continuously are served in strict rotation 0,1,…,N-1,0.
- **Wrap:** `rr_ptr` wraps from `NUM_MASTERS-1` to 0.
- **Width:** `rr_ptr` and `owner` are `$clog2(NUM_MASTERS)` bits.

## Configuration
- Macro: `DBUS_ARB_CHECK_EN`.
- **Defined:** the block includes concurrent assertions, sampled at negedge `clk`, that flag each of these with `$error`:
  - `s.rvalid` while in IDLE;
  - a non-granted master changing `addr`/`we`/`wdata` while its `req` is held;
  - more than one `gnt` high;
  - a `gnt` without `req`.
- **Undefined:** no assertions are compiled; the functional behaviour is identical.

## Structure
- Package `dbus_arbiter_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_WAIT_RSP} arb_state_t`;
  - `DBUS_ARB_MAX_MASTERS = 8`.
- Sub-module `rr_picker`:
  - Purely combinational.
  - Inputs: `req[NUM_MASTERS]` and `ptr`.
  - Outputs: `sel` and `any`.
- The top level holds the FSM, the `owner`/`rr_ptr` registers and the mux/demux logic.

## Test plan
- **Single request:** master 1 writes `addr`=0x004, `wdata`=0xA5A5_0001.
  - Required: `m[1].gnt`=1 in the same cycle and the slave sees the exact fields.
  - Required: `m[1].rvalid`=1 one cycle later while `m[0]` sees nothing.
- **Contention:** both masters read 0x000 continuously for 6 cycles starting from reset.
  - Required: grant order 0,1,0,1,0,1.
  - Required: each master's `rdata` matches the slave value for its own request.
- **Back-to-back:** master 0 issues 4 consecutive reads.
  - Required: 4 grants in 4 consecutive cycles.
  - Required: `busy`=1 from the first grant until the last `rvalid`.
- **Reset mid-transaction:** assert `rst_n`=0 during WAIT_RSP.
  - Required: all `gnt`/`rvalid`=0 and `busy`=0 immediately.
  - Required: the next request after reset is granted to master 0 (`rr_ptr`=0).
- **Wrap with `NUM_MASTERS`=3:** only masters 2 and 0 request.
  - Required: grants alternate 0,2,0,2, and `rr_ptr` wraps 2→0 with no idle cycle.
- **With `DBUS_ARB_CHECK_EN` defined:** inject `s.rvalid`=1 in IDLE.
  - Required: an assertion error is reported and no master `rvalid` is asserted.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// Shared types and sizing for the data_bus arbiter.
package dbus_arbiter_pkg;

  localparam int unsigned DBUS_ARB_MAX_MASTERS = 8;
  localparam int unsigned DBUS_ADDR_W          = 32;
  localparam int unsigned DBUS_DATA_W          = 32;

  typedef enum logic {ARB_IDLE, ARB_WAIT_RSP} arb_state_t;

  // Request payload carried alongside req on the data_bus.
  typedef struct packed {
    logic                   we;
    logic [DBUS_ADDR_W-1:0] addr;
    logic [DBUS_DATA_W-1:0] wdata;
  } dbus_req_t;

endpackage

// File: rtl/dbus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned PTR_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [PTR_W-1:0]       sel,
  output logic                   any
);

  int unsigned idx;

  // Scan farthest-to-nearest from ptr so the nearest requester wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = (32'(ptr) + NUM_MASTERS - 1 - k) % NUM_MASTERS;
      if (req[PTR_W'(idx)]) begin
        sel = PTR_W'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one data_bus slave among NUM_MASTERS masters, one outstanding
// transaction, round-robin arbitration, response routed to the issuer.
// Optional protocol checks: define DBUS_ARB_CHECK_EN.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_MASTERS-1:0]                  m_req,
  input  dbus_req_t [NUM_MASTERS-1:0]             m_cmd,
  output logic [NUM_MASTERS-1:0]                  m_gnt,
  output logic [NUM_MASTERS-1:0]                  m_rvalid,
  output logic [NUM_MASTERS-1:0][DBUS_DATA_W-1:0] m_rdata,
  output logic                                    s_req,
  output dbus_req_t                               s_cmd,
  input  logic                                    s_gnt,
  input  logic                                    s_rvalid,
  input  logic [DBUS_DATA_W-1:0]                  s_rdata,
  output logic                                    busy
);

  localparam int unsigned PTR_W = $clog2(NUM_MASTERS);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] sel;
  logic             any_req;
  logic             arb_active;
  logic             grant_fire;

  rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .PTR_W      (PTR_W)
  ) u_picker (
    .req(m_req),
    .ptr(rr_ptr_q),
    .sel(sel),
    .any(any_req)
  );

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Arbitration, request mux, grant/response demux and next state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    s_req      = 1'b0;
    s_cmd      = '0;
    m_gnt      = '0;
    m_rvalid   = '0;
    m_rdata    = '0;
    grant_fire = 1'b0;
    // A response frees the slot, so the next grant can overlap it.
    arb_active = (state_q == ARB_IDLE) || s_rvalid;

    if (arb_active && any_req) begin
      s_req      = 1'b1;
      s_cmd      = m_cmd[sel];
      m_gnt[sel] = s_gnt;
      grant_fire = s_gnt;
    end

    m_rdata[owner_q] = s_rdata;
    if (state_q == ARB_WAIT_RSP) begin
      m_rvalid[owner_q] = s_rvalid;
    end

    case (state_q)
      ARB_IDLE:     if (grant_fire) state_d = ARB_WAIT_RSP;
      ARB_WAIT_RSP: if (s_rvalid && !grant_fire) state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase

    if (grant_fire) begin
      owner_d  = sel;
      rr_ptr_d = (sel == PTR_W'(NUM_MASTERS - 1)) ? '0 : sel + PTR_W'(1);
    end
  end

  assign busy = (state_q == ARB_WAIT_RSP);

`ifdef DBUS_ARB_CHECK_EN
  // Protocol checks on both sides of the arbiter.
  a_rvalid_in_idle: assert property (@(negedge clk) disable iff (!rst_n)
    !(state_q == ARB_IDLE && s_rvalid))
    else $error("dbus_arbiter: s_rvalid while idle");

  a_gnt_onehot: assert property (@(negedge clk) disable iff (!rst_n)
    $onehot0(m_gnt))
    else $error("dbus_arbiter: more than one gnt");

  a_gnt_needs_req: assert property (@(negedge clk) disable iff (!rst_n)
    (m_gnt & ~m_req) == '0)
    else $error("dbus_arbiter: gnt without req");

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_hold
    a_hold_fields: assert property (@(negedge clk) disable iff (!rst_n)
      (m_req[i] && !m_gnt[i]) |=> (!m_req[i] || $stable(m_cmd[i])))
      else $error("dbus_arbiter: master %0d changed fields while waiting", i);
  end
`else
  // Protocol checks compiled out; behaviour unchanged.
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: a 2-master and a 3-master instance.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  typedef struct {
    int          cyc;
    int          gm;     // granted master, -1 none
    logic        sreq;
    dbus_req_t   pl;     // expected slave-side fields
    int          rm;     // master seeing rvalid, -1 none
    logic [31:0] rdata;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  exp_t q2[$];
  exp_t q3[$];

  // 2-master instance
  logic [1:0]        m2_req;
  dbus_req_t [1:0]   m2_cmd;
  logic [1:0]        m2_gnt, m2_rvalid;
  logic [1:0][31:0]  m2_rdata;
  logic              s2_req, s2_gnt, s2_rvalid, busy2, inj2;
  dbus_req_t         s2_cmd;
  logic [31:0]       s2_rdata;

  // 3-master instance
  logic [2:0]        m3_req;
  dbus_req_t [2:0]   m3_cmd;
  logic [2:0]        m3_gnt, m3_rvalid;
  logic [2:0][31:0]  m3_rdata;
  logic              s3_req, s3_gnt, s3_rvalid, busy3;
  dbus_req_t         s3_cmd;
  logic [31:0]       s3_rdata;

  dbus_arbiter #(.NUM_MASTERS(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .m_req(m2_req), .m_cmd(m2_cmd), .m_gnt(m2_gnt), .m_rvalid(m2_rvalid), .m_rdata(m2_rdata),
    .s_req(s2_req), .s_cmd(s2_cmd), .s_gnt(s2_gnt), .s_rvalid(s2_rvalid), .s_rdata(s2_rdata),
    .busy(busy2)
  );

  dbus_arbiter #(.NUM_MASTERS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .m_req(m3_req), .m_cmd(m3_cmd), .m_gnt(m3_gnt), .m_rvalid(m3_rvalid), .m_rdata(m3_rdata),
    .s_req(s3_req), .s_cmd(s3_cmd), .s_gnt(s3_gnt), .s_rvalid(s3_rvalid), .s_rdata(s3_rdata),
    .busy(busy3)
  );

  // Slave models: rvalid one cycle after grant, rdata = {A0, serial, addr[15:0]}.
  logic        sv2, sv3;
  logic [7:0]  ser2, ser3;
  logic [31:0] srd2, srd3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv2 <= 1'b0; ser2 <= 8'd0; srd2 <= 32'd0;
      sv3 <= 1'b0; ser3 <= 8'd0; srd3 <= 32'd0;
    end else begin
      sv2 <= s2_req && s2_gnt;
      if (s2_req && s2_gnt) begin
        srd2 <= {8'hA0, ser2, s2_cmd.addr[15:0]};
        ser2 <= ser2 + 8'd1;
      end
      sv3 <= s3_req && s3_gnt;
      if (s3_req && s3_gnt) begin
        srd3 <= {8'hA0, ser3, s3_cmd.addr[15:0]};
        ser3 <= ser3 + 8'd1;
      end
    end
  end

  assign s2_rvalid = sv2 | inj2;
  assign s2_rdata  = srd2;
  assign s3_rvalid = sv3;
  assign s3_rdata  = srd3;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [7:0] oh(input int i);
    oh = (i < 0) ? 8'h00 : (8'h01 << i);
  endfunction

  function automatic dbus_req_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
    dbus_req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  task automatic exp2(input logic [1:0] req, input dbus_req_t c0, input dbus_req_t c1,
                      input int ep, input int gm, input int rm,
                      input logic [31:0] rd, input logic bz);
    exp_t e;
    m2_req = req; m2_cmd[0] = c0; m2_cmd[1] = c1;
    e.cyc = cyc; e.gm = gm; e.sreq = (ep >= 0); e.rm = rm; e.rdata = rd; e.busy = bz;
    if (ep == 0) e.pl = c0;
    else if (ep == 1) e.pl = c1;
    else e.pl = '0;
    q2.push_back(e);
  endtask

  task automatic exp3(input logic [2:0] req, input dbus_req_t c0, input dbus_req_t c2,
                      input int ep, input int gm, input int rm,
                      input logic [31:0] rd, input logic bz);
    exp_t e;
    m3_req = req; m3_cmd[0] = c0; m3_cmd[1] = '0; m3_cmd[2] = c2;
    e.cyc = cyc; e.gm = gm; e.sreq = (ep >= 0); e.rm = rm; e.rdata = rd; e.busy = bz;
    if (ep == 0) e.pl = c0;
    else if (ep == 2) e.pl = c2;
    else e.pl = '0;
    q3.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 2-master instance.
  always @(negedge clk) begin
    exp_t e;
    if (q2.size() > 0 && q2[0].cyc == cyc) begin
      e = q2.pop_front();
      chk("gnt2",    64'(m2_gnt),         64'(oh(e.gm)));
      chk("sreq2",   64'(s2_req),         64'(e.sreq));
      chk("s_we2",   64'(s2_cmd.we),      64'(e.pl.we));
      chk("s_addr2", 64'(s2_cmd.addr),    64'(e.pl.addr));
      chk("s_wd2",   64'(s2_cmd.wdata),   64'(e.pl.wdata));
      chk("rvalid2", 64'(m2_rvalid),      64'(oh(e.rm)));
      if (e.rm >= 0) begin
        for (int j = 0; j < 2; j++) begin
          if (j == e.rm) chk("rdata2", 64'(m2_rdata[j]), 64'(e.rdata));
          else           chk("rdata2_other", 64'(m2_rdata[j]), 64'd0);
        end
      end
      chk("busy2",   64'(busy2),          64'(e.busy));
    end
  end

  // Monitor for the 3-master instance.
  always @(negedge clk) begin
    exp_t e;
    if (q3.size() > 0 && q3[0].cyc == cyc) begin
      e = q3.pop_front();
      chk("gnt3",    64'(m3_gnt),         64'(oh(e.gm)));
      chk("sreq3",   64'(s3_req),         64'(e.sreq));
      chk("s_addr3", 64'(s3_cmd.addr),    64'(e.pl.addr));
      chk("rvalid3", 64'(m3_rvalid),      64'(oh(e.rm)));
      if (e.rm >= 0) begin
        for (int j = 0; j < 3; j++) begin
          if (j == e.rm) chk("rdata3", 64'(m3_rdata[j]), 64'(e.rdata));
          else           chk("rdata3_other", 64'(m3_rdata[j]), 64'd0);
        end
      end
      chk("busy3",   64'(busy3),          64'(e.busy));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    dbus_req_t z, p, w, p0, p2;
    z = '0;
    m2_req = '0; m2_cmd = '0; s2_gnt = 1'b1; inj2 = 1'b0;
    m3_req = '0; m3_cmd = '0; s3_gnt = 1'b1;
    tick();

    // Reset state
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);
    exp3(3'b000, z, z, -1, -1, -1, 32'd0, 1'b0);
    tick();
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Single write from master 1
    w = mk(1'b1, 32'h004, 32'hA5A5_0001);
    exp2(2'b10, z, w, 1, 1, -1, 32'd0, 1'b0);                 tick();
    exp2(2'b00, z, z, -1, -1, 1, 32'hA000_0004, 1'b1);         tick();
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);                tick();

    // Reset in WAIT_RSP after a grant to master 0
    p = mk(1'b0, 32'h008, 32'd0);
    exp2(2'b01, p, z, 0, 0, -1, 32'd0, 1'b0);                 tick();
    rst_n = 1'b0;
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);                tick();
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);                tick();
    rst_n = 1'b1;

    // Contention from reset: rotation 0,1,0,1,0,1
    p = mk(1'b0, 32'h000, 32'd0);
    for (int i = 0; i < 6; i++) begin
      exp2(2'b11, p, p, i % 2, i % 2, (i == 0) ? -1 : (i - 1) % 2,
           32'hA000_0000 | (32'(i - 1) << 16), i > 0);
      tick();
    end
    exp2(2'b00, z, z, -1, -1, 1, 32'hA005_0000, 1'b1);         tick();
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);                tick();

    // Back-to-back reads from master 0
    for (int i = 0; i < 4; i++) begin
      exp2(2'b01, mk(1'b0, 32'h010 + 32'(4 * i), 32'd0), z, 0, 0, (i == 0) ? -1 : 0,
           32'hA000_0000 | (32'(5 + i) << 16) | (32'h010 + 32'(4 * (i - 1))), i > 0);
      tick();
    end
    exp2(2'b00, z, z, -1, -1, 0, 32'hA009_001C, 1'b1);         tick();
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);                tick();

    // Slave not ready: request forwarded, no grant, then granted
    w = mk(1'b1, 32'h020, 32'h0000_1234);
    s2_gnt = 1'b0;
    exp2(2'b10, z, w, 1, -1, -1, 32'd0, 1'b0);                tick();
    s2_gnt = 1'b1;
    exp2(2'b10, z, w, 1, 1, -1, 32'd0, 1'b0);                 tick();
    exp2(2'b00, z, z, -1, -1, 1, 32'hA00A_0020, 1'b1);         tick();
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);                tick();

    // Stray rvalid in IDLE goes nowhere
    inj2 = 1'b1;
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);                tick();
    inj2 = 1'b0;
    exp2(2'b00, z, z, -1, -1, -1, 32'd0, 1'b0);                tick();

    // Three masters, only 0 and 2 requesting: 0,2,0,2 with wrap
    p0 = mk(1'b0, 32'h100, 32'd0);
    p2 = mk(1'b0, 32'h200, 32'd0);
    exp3(3'b101, p0, p2, 0, 0, -1, 32'd0, 1'b0);              tick();
    exp3(3'b101, p0, p2, 2, 2, 0, 32'hA000_0100, 1'b1);       tick();
    exp3(3'b101, p0, p2, 0, 0, 2, 32'hA001_0200, 1'b1);       tick();
    exp3(3'b101, p0, p2, 2, 2, 0, 32'hA002_0100, 1'b1);       tick();
    exp3(3'b000, z, z, -1, -1, 2, 32'hA003_0200, 1'b1);       tick();
    exp3(3'b000, z, z, -1, -1, -1, 32'd0, 1'b0);              tick();

    tick();
    chk("scoreboard_drain", 64'(q2.size() + q3.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
